// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_arbiter
//  Description : Round-robin sequencer sharing one combinational IEEE-754
//                single-precision adder among NUM_REQ requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [15:0]           ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_id_q;
    logic [31:0]     r_add_a;
    logic [31:0]     r_add_b;
    logic [31:0]     r_rsp_data;
    logic [ID_W-1:0] r_rsp_id;
    logic [15:0]     r_ops_done;

    logic            w_gnt_vld;
    logic [ID_W-1:0] w_gnt_idx;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    logic            w_gnt_now;
    logic            w_rsp_fire;

    // Rotating priority: first pass takes the lowest valid index at or above
    // the pointer; if none, the second pass wraps to the lowest valid overall.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_vld && req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_vld && req_valid[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_a = req_a[32*i +: 32];
                w_sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign w_ptr_nxt  = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    assign w_gnt_now  = (r_state == S_IDLE) && w_gnt_vld;
    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_gnt_now && (w_gnt_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Adder operands only change on a grant so the shared adder sees a
    // stable pair for the whole CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_id_q     <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_ops_done <= '0;
        end else begin
            if (w_gnt_now) begin
                r_add_a  <= w_sel_a;
                r_add_b  <= w_sel_b;
                r_id_q   <= w_gnt_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_CALC) begin
                r_rsp_data <= add_result;
                r_rsp_id   <= r_id_q;
            end
            if (w_rsp_fire) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign ops_done  = r_ops_done;
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_arbiter
//  Description : Directed self-checking bench for fp_add_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic [31:0]           add_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
    logic [15:0]           ops_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rr_a   [NUM_REQ];
    logic [31:0] rr_b   [NUM_REQ];
    logic [31:0] rr_sum [NUM_REQ];

    fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared adder: hand-computed sums for the vectors used.
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h411C0000_3F100000: return 32'h41250000;
            64'h411C0000_BF100000: return 32'h41130000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h3F800000_40000000: return 32'h40400000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3F000000_3F000000: return 32'h3F800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    assign add_result = fadd_model(add_a, add_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rr_a[0] = 32'h3F800000; rr_b[0] = 32'h3F800000; rr_sum[0] = 32'h40000000;
        rr_a[1] = 32'h3F800000; rr_b[1] = 32'h40000000; rr_sum[1] = 32'h40400000;
        rr_a[2] = 32'h40000000; rr_b[2] = 32'h40000000; rr_sum[2] = 32'h40800000;
        rr_a[3] = 32'h3F000000; rr_b[3] = 32'h3F000000; rr_sum[3] = 32'h3F800000;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a",     add_a,          32'd0);
        chk("rst_add_b",     add_b,          32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_ops_done",  32'(ops_done),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 0
        set_ops(0, 32'h411C0000, 32'h3F100000);
        req_valid = 4'b0001;
        #1;
        chk("t1_grant_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("t1_calc_ready", 32'(req_ready), 32'h0);
        chk("t1_calc_busy",  32'(busy),      32'd1);
        chk("t1_calc_valid", 32'(rsp_valid), 32'd0);
        chk("t1_add_a",      add_a,          32'h411C0000);
        chk("t1_add_b",      add_b,          32'h3F100000);
        tick();
        chk("t1_rsp_valid",  32'(rsp_valid), 32'd1);
        chk("t1_rsp_data",   rsp_data,       32'h41250000);
        chk("t1_rsp_id",     32'(rsp_id),    32'd0);
        tick();
        chk("t1_ops_done",   32'(ops_done),  32'd1);
        chk("t1_idle_valid", 32'(rsp_valid), 32'd0);
        chk("t1_idle_busy",  32'(busy),      32'd0);

        // Subtraction path from requester 2
        set_ops(2, 32'h411C0000, 32'hBF100000);
        req_valid = 4'b0100;
        #1;
        chk("t2_grant_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk("t2_rsp_data",  rsp_data,       32'h41130000);
        chk("t2_rsp_id",    32'(rsp_id),    32'd2);
        tick();
        chk("t2_ops_done",  32'(ops_done),  32'd2);

        // Round-robin with all requesters continuously valid (pointer reset to 0)
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, rr_a[i], rr_b[i]);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            tick();
            chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr%0d_id", k),    32'(rsp_id),    32'(k % 4));
            chk($sformatf("rr%0d_data", k),  rsp_data,       rr_sum[k % 4]);
            tick();
        end
        chk("rr_ops_done", 32'(ops_done), 32'd8);

        // Backpressure: response held for 5 cycles
        rsp_ready = 1'b0;
        chk("bp_grant_ready", 32'(req_ready), 32'h1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_data", k),  rsp_data,       32'h40000000);
            chk($sformatf("bp%0d_id", k),    32'(rsp_id),    32'd0);
            chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
            tick();
        end
        chk("bp_hold_ops_done", 32'(ops_done), 32'd8);
        rsp_ready = 1'b1;
        tick();
        chk("bp_ops_done",    32'(ops_done),  32'd9);
        chk("bp_next_ready",  32'(req_ready), 32'h2);

        // Asynchronous reset during CALC
        tick();
        chk("ar_calc_busy",  32'(busy), 32'd1);
        chk("ar_calc_add_a", add_a,     32'h3F800000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_busy",      32'(busy),      32'd0);
        chk("ar_add_a",     add_a,          32'd0);
        chk("ar_add_b",     add_b,          32'd0);
        chk("ar_ops_done",  32'(ops_done),  32'd0);
        req_valid = 4'b1010;
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_first_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("ar_rsp_id",   32'(rsp_id), 32'd1);
        chk("ar_rsp_data", rsp_data,    32'h40400000);
        tick();
        chk("ar_ops_done_after", 32'(ops_done), 32'd1);

        // ops_done wrap from 0xFFFF
        force dut.r_ops_done = 16'hFFFF;
        #1;
        release dut.r_ops_done;
        #1;
        chk("wrap_preload", 32'(ops_done), 32'h0000FFFF);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        chk("wrap_resp_hold", 32'(ops_done), 32'h0000FFFF);
        chk("wrap_rsp_data",  rsp_data,      32'h40000000);
        tick();
        chk("wrap_ops_done",  32'(ops_done), 32'h00000000);
        chk("wrap_idle_busy", 32'(busy),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
